// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - CPU-side and RAM-side signal bundle for mem_access_ctrl
//
// Ports (signals):
//   req, we, size, sign_ext, addr, wdata   access request from the CPU datapath
//   rdata, done, misalign, busy            access result / status back to the CPU
//   ram_wea, ram_addra, ram_dina            single-port block RAM write/address/data
//   ram_douta                               RAM read data, one cycle after address
// Modports:
//   slave  - the access controller
//   master - the CPU datapath plus the RAM it drives
interface mem_access_ctrl_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
);
   logic              req;
   logic              we;
   logic [1:0]        size;
   logic              sign_ext;
   logic [31:0]       addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              done;
   logic              misalign;
   logic              busy;
   logic              ram_wea;
   logic [ADDR_W-1:0] ram_addra;
   logic [DATA_W-1:0] ram_dina;
   logic [DATA_W-1:0] ram_douta;

   modport slave (
      input  req, we, size, sign_ext, addr, wdata, ram_douta,
      output rdata, done, misalign, busy, ram_wea, ram_addra, ram_dina
   );

   modport master (
      output req, we, size, sign_ext, addr, wdata, ram_douta,
      input  rdata, done, misalign, busy, ram_wea, ram_addra, ram_dina
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - byte/half/word access controller in front of a 1-cycle-latency block RAM
//
// Ports:
//   clk  - system clock, shared with the RAM
//   rst  - asynchronous active-high reset; all outputs forced to 0
//   bus  - mem_access_ctrl_if.slave:
//          req/we/size/sign_ext/addr/wdata in, rdata/done/misalign/busy out,
//          ram_wea/ram_addra/ram_dina out, ram_douta in
//
// Sub-word stores are done as read-modify-write. Loads are lane-extracted
// and sign/zero extended into a registered rdata.
module mem_access_ctrl #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   mem_access_ctrl_if.slave    bus
);

   typedef enum logic [2:0] {
      IDLE,
      RD_ISSUE,
      RD_WAIT,
      WR,
      DONE,
      ERR
   } state_t;

   state_t      state;

   // Request fields captured in IDLE; only what later states need is kept.
   logic        a_we;
   logic [1:0]  a_size;
   logic        a_sext;
   logic [1:0]  a_lane;
   logic [15:0] a_wdata;

   logic              misaligned;
   logic [7:0]        lane_b;
   logic [15:0]       lane_h;
   logic [DATA_W-1:0] load_val;
   logic [DATA_W-1:0] merge_val;

   // size 11 behaves as word, so size[1] alone marks a word access.
   assign misaligned = ((bus.size == 2'b01) && bus.addr[0]) ||
                       (bus.size[1] && (bus.addr[1:0] != 2'b00));

   // Lane extraction and extension of the word returned by the RAM.
   always_comb begin
      lane_b   = bus.ram_douta[{a_lane, 3'b000} +: 8];
      lane_h   = bus.ram_douta[{a_lane[1], 4'b0000} +: 16];
      load_val = bus.ram_douta;
      case (a_size)
         2'b00:   load_val = {{24{a_sext & lane_b[7]}}, lane_b};
         2'b01:   load_val = {{16{a_sext & lane_h[15]}}, lane_h};
         default: load_val = bus.ram_douta;
      endcase
   end

   // Merge the store data into the word just read back.
   always_comb begin
      merge_val = bus.ram_douta;
      if (a_size == 2'b00)
         merge_val[{a_lane, 3'b000} +: 8] = a_wdata[7:0];
      else if (a_size == 2'b01)
         merge_val[{a_lane[1], 4'b0000} +: 16] = a_wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         a_we          <= 1'b0;
         a_size        <= 2'b00;
         a_sext        <= 1'b0;
         a_lane        <= 2'b00;
         a_wdata       <= '0;
         bus.rdata     <= '0;
         bus.done      <= 1'b0;
         bus.misalign  <= 1'b0;
         bus.busy      <= 1'b0;
         bus.ram_wea   <= 1'b0;
         bus.ram_addra <= '0;
         bus.ram_dina  <= '0;
      end else begin
         // Pulse outputs default low; ram_addra/ram_dina/rdata hold.
         bus.done     <= 1'b0;
         bus.misalign <= 1'b0;
         bus.ram_wea  <= 1'b0;

         case (state)
            IDLE: begin
               if (bus.req) begin
                  a_we     <= bus.we;
                  a_size   <= bus.size;
                  a_sext   <= bus.sign_ext;
                  a_lane   <= bus.addr[1:0];
                  a_wdata  <= bus.wdata[15:0];
                  bus.busy <= 1'b1;
                  if (misaligned) begin
                     bus.done     <= 1'b1;
                     bus.misalign <= 1'b1;
                     state        <= ERR;
                  end else if (bus.we && bus.size[1]) begin
                     // Full-word store skips the read entirely.
                     bus.ram_addra <= bus.addr[ADDR_W+1:2];
                     bus.ram_dina  <= bus.wdata;
                     bus.ram_wea   <= 1'b1;
                     state         <= WR;
                  end else begin
                     bus.ram_addra <= bus.addr[ADDR_W+1:2];
                     state         <= RD_ISSUE;
                  end
               end
            end

            RD_ISSUE: begin
               // The RAM registers the address at the end of this cycle.
               state <= RD_WAIT;
            end

            RD_WAIT: begin
               if (a_we) begin
                  bus.ram_dina <= merge_val;
                  bus.ram_wea  <= 1'b1;
                  state        <= WR;
               end else begin
                  bus.rdata <= load_val;
                  bus.done  <= 1'b1;
                  state     <= DONE;
               end
            end

            WR: begin
               bus.done <= 1'b1;
               state    <= DONE;
            end

            DONE, ERR: begin
               bus.busy <= 1'b0;
               state    <= IDLE;
            end

            default: begin
               bus.busy <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - scoreboard bench for mem_access_ctrl
module tb_mem_access_ctrl;

   localparam int ADDR_W = 10;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_access_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(32)) bus ();

   mem_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic        exp_mis;
      logic [31:0] exp_rdata;
      int          issue_cyc;
      logic        chained;
      int          exp_lat;
      int          exp_wea;
      logic [9:0]  waddr;
      logic [31:0] wword;
   } sb_t;

   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          wea_cnt = 0;
   int          last_done = 0;
   int          start;
   logic [31:0] ram [1024];
   logic [31:0] ref_mem [1024];
   logic [31:0] last_rdata = 32'h0;
   sb_t         sb [$];
   sb_t         mon_e;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // RAM model: read-first, 1-cycle read latency.
   always @(posedge clk) begin
      if (bus.ram_wea) ram[bus.ram_addra] <= bus.ram_dina;
      bus.ram_douta <= ram[bus.ram_addra];
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: write-pulse checks and scoreboard pop on done.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.ram_wea) begin
            wea_cnt++;
            if (sb.size() == 0) check("wea_unexpected", 1, 0);
            else begin
               check("wea_addr", {22'h0, bus.ram_addra}, {22'h0, sb[0].waddr});
               check("wea_data", bus.ram_dina, sb[0].wword);
            end
         end
         if (bus.done) begin
            if (sb.size() == 0) check("extra_done", 1, 0);
            else begin
               mon_e = sb.pop_front();
               start = mon_e.chained ? last_done + 1 : mon_e.issue_cyc;
               check("misalign", {31'h0, bus.misalign}, {31'h0, mon_e.exp_mis});
               check("rdata", bus.rdata, mon_e.exp_rdata);
               check("latency", cyc - start, mon_e.exp_lat);
               check("wea_pulses", wea_cnt, mon_e.exp_wea);
               check("busy_at_done", {31'h0, bus.busy}, 32'h1);
            end
            wea_cnt   = 0;
            last_done = cyc;
         end else if (bus.misalign) begin
            check("misalign_without_done", 1, 0);
         end
      end
   end

   function automatic logic [31:0] ext_model(input logic [31:0] w, input logic [1:0] sz,
                                             input logic [1:0] off, input logic s);
      logic [31:0] sh;
      sh = w >> (8 * off);
      if (sz[1]) return w;
      if (sz == 2'b00) return (s && sh[7]) ? (sh | 32'hFFFFFF00) : (sh & 32'h000000FF);
      return (s && sh[15]) ? (sh | 32'hFFFF0000) : (sh & 32'h0000FFFF);
   endfunction

   function automatic logic [31:0] merge_model(input logic [31:0] old, input logic [31:0] wd,
                                               input logic [1:0] sz, input logic [1:0] off);
      logic [31:0] m;
      m = ((sz == 2'b00) ? 32'h000000FF : 32'h0000FFFF) << (8 * off);
      return (old & ~m) | ((wd << (8 * off)) & m);
   endfunction

   task automatic expect_access(input logic w, input logic [1:0] sz, input logic s,
                                input logic [31:0] a, input logic [31:0] wd);
      sb_t        e;
      logic [9:0] wa;
      logic       mis;
      wa  = a[11:2];
      mis = ((sz == 2'b01) && a[0]) || (sz[1] && (a[1:0] != 2'b00));
      e.exp_mis   = mis;
      e.issue_cyc = cyc;
      e.chained   = 1'b0;
      e.exp_wea   = 0;
      e.waddr     = wa;
      e.wword     = 32'h0;
      if (mis) begin
         e.exp_lat = 1;
      end else if (!w) begin
         e.exp_lat  = 3;
         last_rdata = ext_model(ref_mem[wa], sz, a[1:0], s);
      end else begin
         e.wword     = sz[1] ? wd : merge_model(ref_mem[wa], wd, sz, a[1:0]);
         ref_mem[wa] = e.wword;
         e.exp_wea   = 1;
         e.exp_lat   = sz[1] ? 2 : 4;
      end
      e.exp_rdata = last_rdata;
      sb.push_back(e);
   endtask

   task automatic drive(input logic w, input logic [1:0] sz, input logic s,
                        input logic [31:0] a, input logic [31:0] wd);
      bus.req      = 1'b1;
      bus.we       = w;
      bus.size     = sz;
      bus.sign_ext = s;
      bus.addr     = a;
      bus.wdata    = wd;
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while (sb.size() != 0 && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (sb.size() != 0) begin
         check("timeout_pending", sb.size(), 0);
         sb.delete();
      end
   endtask

   task automatic access(input logic w, input logic [1:0] sz, input logic s,
                         input logic [31:0] a, input logic [31:0] wd, input bit pulse_busy);
      expect_access(w, sz, s, a, wd);
      drive(w, sz, s, a, wd);
      @(negedge clk);
      bus.req = 1'b0;
      if (pulse_busy) begin
         // Stray requests while busy must be dropped.
         @(negedge clk);
         drive(1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
         @(negedge clk);
         bus.req = 1'b0;
      end
      wait_drain(30);
      @(negedge clk);
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_rdata"}, bus.rdata, 32'h0);
      check({tag, "_done"}, {31'h0, bus.done}, 32'h0);
      check({tag, "_busy"}, {31'h0, bus.busy}, 32'h0);
      check({tag, "_misalign"}, {31'h0, bus.misalign}, 32'h0);
      check({tag, "_wea"}, {31'h0, bus.ram_wea}, 32'h0);
      check({tag, "_addra"}, {22'h0, bus.ram_addra}, 32'h0);
      check({tag, "_dina"}, bus.ram_dina, 32'h0);
   endtask

   initial begin
      logic [31:0] ra;
      int          n;
      for (int i = 0; i < 1024; i++) begin
         ram[i]     = 32'h0;
         ref_mem[i] = 32'h0;
      end
      bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'b00;
      bus.sign_ext = 1'b0; bus.addr = 32'h0; bus.wdata = 32'h0;

      repeat (3) @(negedge clk);
      check_reset("por");
      rst = 1'b0;
      @(negedge clk);

      // Word store, then loads of every lane width.
      access(1'b1, 2'b10, 1'b0, 32'h4, 32'hDEADBEEF, 0);
      access(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 0);
      access(1'b0, 2'b00, 1'b1, 32'h7, 32'h0, 0);
      access(1'b0, 2'b00, 1'b0, 32'h7, 32'h0, 0);
      access(1'b0, 2'b01, 1'b1, 32'h6, 32'h0, 0);
      access(1'b0, 2'b01, 1'b1, 32'h4, 32'h0, 0);

      // Sub-word stores via read-modify-write.
      access(1'b1, 2'b00, 1'b0, 32'h5, 32'h12345611, 0);
      access(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 0);
      access(1'b1, 2'b01, 1'b0, 32'h6, 32'h0000CAFE, 0);
      access(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 0);

      // Misaligned accesses leave RAM and rdata alone.
      access(1'b0, 2'b01, 1'b1, 32'h5, 32'h0, 0);
      access(1'b1, 2'b10, 1'b0, 32'h6, 32'h11111111, 0);
      access(1'b1, 2'b11, 1'b0, 32'h1, 32'h22222222, 0);
      access(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 0);

      // size 11 as word, high address bits alias, zero-extended half.
      access(1'b0, 2'b11, 1'b1, 32'h4, 32'h0, 0);
      access(1'b0, 2'b10, 1'b0, 32'hFFFF_1004, 32'h0, 0);
      access(1'b0, 2'b01, 1'b0, 32'h6, 32'h0, 0);

      // req held high across three loads.
      for (int k = 0; k < 3; k++) begin
         expect_access(1'b0, 2'b00, 1'b0, 32'h4, 32'h0);
         if (k > 0) sb[sb.size()-1].chained = 1'b1;
      end
      drive(1'b0, 2'b00, 1'b0, 32'h4, 32'h0);
      wait_drain(40);
      bus.req = 1'b0;
      repeat (6) @(negedge clk);

      // Stray req pulses during a sub-word store.
      access(1'b1, 2'b00, 1'b0, 32'h8, 32'h000000AB, 1);
      access(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 0);
      repeat (4) @(negedge clk);

      // Random mix over a small aliased window.
      for (int k = 0; k < 24; k++) begin
         ra = $urandom_range(0, 63) | ($urandom_range(0, 3) << 12);
         access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                ra, $urandom, 0);
      end

      // Reset while the RMW write is on the RAM port.
      expect_access(1'b1, 2'b00, 1'b0, 32'h11, 32'h00000055);
      drive(1'b1, 2'b00, 1'b0, 32'h11, 32'h00000055);
      @(negedge clk);
      bus.req = 1'b0;
      n = 0;
      while (!bus.ram_wea && n < 10) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("rmw_reached_wr", {31'h0, bus.ram_wea}, 32'h1);
      rst = 1'b1;
      #1;
      check_reset("rst_in_wr");
      sb.delete();
      wea_cnt    = 0;
      last_rdata = 32'h0;
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      access(1'b1, 2'b10, 1'b0, 32'h10, 32'h0BADF00D, 0);
      access(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 0);
      access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0);
      repeat (4) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
